// File: rtl/usb_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the USB UART byte pipeline.
// Each granted packet goes out as header byte, payload, then an XOR checksum trailer.
module usb_tx_arbiter #(
    parameter int         N_SRC   = 4,
    parameter logic [3:0] HDR_TAG = 4'hA,
    parameter int         TIMEOUT = 4800
) (
    input  logic                 clk_48mhz,
    input  logic                 reset_n,
    input  logic [8*N_SRC-1:0]   src_data,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [N_SRC-1:0]     src_last,
    output logic [N_SRC-1:0]     src_ready,
    output logic [7:0]           uart_in_data,
    output logic                 uart_in_valid,
    input  logic                 uart_in_ready,
    output logic                 busy,
    output logic [1:0]           grant_id,
    output logic                 abort
);

    typedef enum logic [1:0] {IDLE, BODY, CSUM} state_t;

    state_t      state;
    logic [1:0]  last_grant;
    logic [7:0]  csum;
    logic [15:0] stall_cnt;

    logic        slot_free;
    logic        g_valid;
    logic        g_last;
    logic [7:0]  g_data;
    logic        src_hs;
    logic        stall_done;
    logic        pick_found;
    logic [1:0]  pick_id;
    logic [1:0]  cand;

    assign slot_free  = !uart_in_valid || uart_in_ready;
    assign g_valid    = src_valid[grant_id];
    assign g_last     = src_last[grant_id];
    assign g_data     = src_data[{grant_id, 3'b000} +: 8];
    assign src_hs     = (state == BODY) && g_valid && slot_free;
    assign stall_done = (stall_cnt == 16'(TIMEOUT));
    assign busy       = (state != IDLE);

    // Round-robin scan starting just after the most recent grant.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = 2'((int'(last_grant) + 1 + k) % N_SRC);
            if (!pick_found && src_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (state == BODY)
            src_ready[grant_id] = slot_free;
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            state         <= IDLE;
            uart_in_valid <= 1'b0;
            uart_in_data  <= 8'h00;
            grant_id      <= 2'd0;
            abort         <= 1'b0;
            last_grant    <= 2'(N_SRC - 1);
            csum          <= 8'h00;
            stall_cnt     <= 16'd0;
        end else begin
            abort <= 1'b0;
            // An accepted byte frees the slot unless something new loads below.
            if (uart_in_ready)
                uart_in_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found && slot_free) begin
                        uart_in_data  <= {HDR_TAG, 2'b00, pick_id};
                        uart_in_valid <= 1'b1;
                        csum          <= {HDR_TAG, 2'b00, pick_id};
                        grant_id      <= pick_id;
                        last_grant    <= pick_id;
                        stall_cnt     <= 16'd0;
                        state         <= BODY;
                    end
                end
                BODY: begin
                    if (src_hs) begin
                        uart_in_data  <= g_data;
                        uart_in_valid <= 1'b1;
                        csum          <= csum ^ g_data;
                        stall_cnt     <= 16'd0;
                        if (g_last)
                            state <= CSUM;
                    end else begin
                        if (!g_valid && !stall_done)
                            stall_cnt <= stall_cnt + 16'd1;
                        // Inverted trailer marks the frame as aborted to the host.
                        if (stall_done && slot_free) begin
                            uart_in_data  <= csum ^ 8'hFF;
                            uart_in_valid <= 1'b1;
                            abort         <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                end
                CSUM: begin
                    if (slot_free) begin
                        uart_in_data  <= csum;
                        uart_in_valid <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Scoreboard bench for usb_tx_arbiter: directed packets, expected UART bytes queued up front.
module tb_usb_tx_arbiter;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] src_data = '0;
    logic [3:0]  src_valid = '0;
    logic [3:0]  src_last = '0;
    logic [3:0]  src_ready;
    logic [7:0]  uart_in_data;
    logic        uart_in_valid;
    logic        uart_in_ready = 1'b1;
    logic        busy;
    logic [1:0]  grant_id;
    logic        abort;

    logic [7:0]  d1_data = '0;
    logic        d1_valid = 1'b0;
    logic        d1_last = 1'b0;
    logic        d1_ready;
    logic [7:0]  u1_data;
    logic        u1_valid;
    logic        busy1;
    logic [1:0]  grant1;
    logic        abort1;

    int total = 0;
    int bad = 0;
    bq_t q0;
    bq_t q1;
    int aborts = 0;
    logic [7:0] frame_xor = 8'h00;
    logic held = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic started1 = 1'b0;

    always #5 clk = ~clk;

    usb_tx_arbiter #(.N_SRC(4), .HDR_TAG(4'hA), .TIMEOUT(8)) dut (
        .clk_48mhz(clk), .reset_n(reset_n),
        .src_data(src_data), .src_valid(src_valid), .src_last(src_last),
        .src_ready(src_ready),
        .uart_in_data(uart_in_data), .uart_in_valid(uart_in_valid),
        .uart_in_ready(uart_in_ready),
        .busy(busy), .grant_id(grant_id), .abort(abort)
    );

    usb_tx_arbiter #(.N_SRC(1), .HDR_TAG(4'hA), .TIMEOUT(8)) dut1 (
        .clk_48mhz(clk), .reset_n(reset_n),
        .src_data(d1_data), .src_valid(d1_valid), .src_last(d1_last),
        .src_ready(d1_ready),
        .uart_in_data(u1_data), .uart_in_valid(u1_valid),
        .uart_in_ready(uart_in_ready),
        .busy(busy1), .grant_id(grant1), .abort(abort1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push0(input bq_t b);
        foreach (b[i]) q0.push_back(b[i]);
    endtask

    // Called right after a negedge drive; returns just before the accepting posedge.
    task automatic wait_hs0(input int s);
        int n = 0;
        forever begin
            #4;
            if (src_ready[s] && src_valid[s]) break;
            n++;
            if (n > 100) begin
                total++; bad++;
                $display("FAIL hs_timeout src=%0d: got no src_ready expected handshake", s);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_hs1();
        int n = 0;
        forever begin
            #4;
            if (d1_ready && d1_valid) break;
            n++;
            if (n > 100) begin
                total++; bad++;
                $display("FAIL hs1_timeout: got no src_ready expected handshake");
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send0(input int s, input bq_t b, input bit with_last);
        for (int i = 0; i < b.size(); i++) begin
            @(negedge clk);
            src_data[8*s +: 8] = b[i];
            src_valid[s] = 1'b1;
            src_last[s] = with_last && (i == b.size() - 1);
            wait_hs0(s);
        end
        @(negedge clk);
        src_valid[s] = 1'b0;
        src_last[s] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor for the 4-source instance: scoreboard pops, hold and backpressure checks.
    always begin
        @(negedge clk);
        #4;
        if (held) begin
            check("hold_valid", uart_in_valid, 1);
            check("hold_data", uart_in_data, held_data);
        end
        held = 1'b0;
        if (uart_in_valid && !uart_in_ready && reset_n) begin
            held = 1'b1;
            held_data = uart_in_data;
            check("ready_when_full", src_ready, 0);
        end
        if (uart_in_valid && uart_in_ready) begin
            frame_xor = frame_xor ^ uart_in_data;
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_byte: got %0h expected none", uart_in_data);
            end else begin
                check("uart_byte", uart_in_data, q0.pop_front());
            end
        end
        if (abort) aborts++;
    end

    // Monitor for the single-source instance, including the no-gap check.
    always begin
        @(negedge clk);
        #4;
        if (started1 && q1.size() != 0)
            check("n1_no_gap", u1_valid, 1);
        if (u1_valid && uart_in_ready) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_byte1: got %0h expected none", u1_data);
            end else begin
                check("n1_byte", u1_data, q1.pop_front());
                started1 = 1'b1;
            end
        end
        if (q1.size() == 0) started1 = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #4;
        check("rst_valid", uart_in_valid, 0);
        check("rst_data", uart_in_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_abort", abort, 0);
        check("rst_ready", src_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single frame from source 0
        frame_xor = 8'h00;
        push0('{8'hA0, 8'h11, 8'h22, 8'h93});
        send0(0, '{8'h11, 8'h22}, 1'b1);
        #4;
        check("t1_busy_mid", busy, 1);
        check("t1_grant", grant_id, 0);
        drain();
        check("t1_busy_end", busy, 0);
        check("t1_xor", frame_xor, 8'h00);

        // Sources 1 and 3 contending with 1-byte packets
        push0('{8'hA1, 8'h31, 8'h90, 8'hA3, 8'h71, 8'hD2,
                8'hA1, 8'h32, 8'h93, 8'hA3, 8'h72, 8'hD1,
                8'hA1, 8'h33, 8'h92, 8'hA3, 8'h73, 8'hD0});
        fork
            begin
                send0(1, '{8'h31}, 1'b1);
                send0(1, '{8'h32}, 1'b1);
                send0(1, '{8'h33}, 1'b1);
            end
            begin
                send0(3, '{8'h71}, 1'b1);
                send0(3, '{8'h72}, 1'b1);
                send0(3, '{8'h73}, 1'b1);
            end
        join
        drain();

        // Backpressure: uart_in_ready toggling 1,0,0,1
        push0('{8'hA0, 8'h40, 8'h41, 8'h42, 8'hE3});
        fork
            send0(0, '{8'h40, 8'h41, 8'h42}, 1'b1);
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                uart_in_ready = (i % 4 == 0) || (i % 4 == 3);
            end
        join
        @(negedge clk);
        uart_in_ready = 1'b1;
        drain();

        // Timeout abort from source 2
        aborts = 0;
        frame_xor = 8'h00;
        push0('{8'hA2, 8'h05, 8'h58});
        send0(2, '{8'h05}, 1'b0);
        #4;
        check("t4_busy_mid", busy, 1);
        check("t4_grant", grant_id, 2);
        repeat (15) @(negedge clk);
        drain();
        check("t4_aborts", aborts, 1);
        check("t4_busy_end", busy, 0);
        check("t4_xor", frame_xor, 8'hFF);

        // Reset mid-payload
        push0('{8'hA1, 8'h61});
        @(negedge clk);
        src_data[15:8] = 8'h61;
        src_valid[1] = 1'b1;
        src_last[1] = 1'b0;
        wait_hs0(1);
        @(negedge clk);
        src_data[15:8] = 8'h62;
        reset_n = 1'b0;
        @(negedge clk);
        src_valid[1] = 1'b0;
        #4;
        check("t5_rst_valid", uart_in_valid, 0);
        check("t5_rst_data", uart_in_data, 8'h00);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_grant", grant_id, 0);
        check("t5_rst_abort", abort, 0);
        check("t5_rst_ready", src_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        push0('{8'hA0, 8'h0A, 8'hAA, 8'hA1, 8'h1B, 8'hBA});
        fork
            send0(0, '{8'h0A}, 1'b1);
            send0(1, '{8'h1B}, 1'b1);
        join
        drain();

        // N_SRC=1, back-to-back frames with no idle gap
        q1.push_back(8'hA0); q1.push_back(8'h01); q1.push_back(8'h02); q1.push_back(8'hA3);
        q1.push_back(8'hA0); q1.push_back(8'h03); q1.push_back(8'h04); q1.push_back(8'hA7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d1_data = 8'(i + 1);
            d1_last = (i % 2 == 1);
            d1_valid = 1'b1;
            wait_hs1();
        end
        @(negedge clk);
        d1_valid = 1'b0;
        d1_last = 1'b0;
        drain();
        check("t6_busy_end", busy1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
